// File: rtl/tid_reorder_buffer_pkg.sv
// Shared types for the tag-indexed reorder buffer.
package tid_reorder_buffer_pkg;
    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/tid_reorder_buffer_sdp_ram.sv
// Simple dual-port payload store: one write port, one registered read port, common clock.
module sdp_ram #(
    parameter int W  = 1,
    parameter int D  = 2048,
    parameter int AW = $clog2(D)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [D];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read returns the old contents on a same-address collision; the top bypasses.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/tid_reorder_buffer.sv
// Tag-indexed reorder buffer: out-of-order result writes, in-order show-ahead pops.
// Define TID_REORDER_CHECK_EN to add simulation checks for live-slot overwrites and X controls.
module tid_reorder_buffer
    import tid_reorder_buffer_pkg::*;
#(
    parameter int W           = 1,
    parameter int D           = 2048,
    parameter int FULL_MARGIN = 16,
    parameter int AW          = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_v,
    input  logic [AW-1:0] i_a,
    input  logic [W-1:0]  i_d,
    output logic [15:0]   i_c,
    output logic          i_f,
    input  logic          o_r,
    output logic          o_v,
    output logic [W-1:0]  o_d
);

    localparam cnt_t CNT_MAX = cnt_t'(D);
    localparam int   FULL_THR = D - FULL_MARGIN;

    // Handshake: a pop happens on any cycle with o_v & o_r; o_r is ignored while o_v is low.

    logic [D-1:0]  valid;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] next_ptr;
    logic          pop;
    logic          slot_live;
    logic          inc;
    logic          head_hit;
    logic          o_v_q;
    logic          byp_sel;
    logic [W-1:0]  byp_d;
    logic [W-1:0]  ram_q;
    cnt_t          cnt_q;
    cnt_t          cnt_next;
    logic          full_q;
    int            cnt_i;

    assign pop       = o_v_q & o_r;
    assign next_ptr  = rd_ptr + AW'(pop);
    // A slot popped this cycle counts as free for a same-cycle write to it.
    assign slot_live = valid[i_a] & ~(pop & (i_a == rd_ptr));
    assign inc       = i_v & ~slot_live;
    assign head_hit  = i_v & (i_a == next_ptr);

    always_comb begin
        cnt_next = cnt_q;
        case ({inc, pop})
            2'b10:   cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + cnt_t'(1);
            2'b01:   cnt_next = (cnt_q == '0) ? cnt_q : cnt_q - cnt_t'(1);
            default: cnt_next = cnt_q;
        endcase
        cnt_i = int'(cnt_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= '0;
            rd_ptr  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            o_v_q   <= 1'b0;
            byp_sel <= 1'b0;
            byp_d   <= '0;
        end else begin
            // Set after clear so a write to the slot being popped keeps it valid.
            if (pop) valid[rd_ptr] <= 1'b0;
            if (i_v) valid[i_a]    <= 1'b1;
            rd_ptr  <= next_ptr;
            cnt_q   <= cnt_next;
            full_q  <= (cnt_i >= FULL_THR);
            o_v_q   <= valid[next_ptr] | head_hit;
            byp_sel <= head_hit;
            if (head_hit) byp_d <= i_d;
        end
    end

    sdp_ram #(
        .W  (W),
        .D  (D),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (i_v & rst_n),
        .waddr (i_a),
        .wdata (i_d),
        .raddr (next_ptr),
        .rdata (ram_q)
    );

    assign o_v = o_v_q;
    assign o_d = byp_sel ? byp_d : ram_q;
    assign i_c = cnt_q;
    assign i_f = full_q;

`ifdef TID_REORDER_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!$isunknown({i_v, o_r}))
                else $error("tid_reorder_buffer: X on i_v/o_r");
            if (i_v === 1'b1)
                assert (!slot_live)
                    else $error("tid_reorder_buffer: write to live slot %0d", i_a);
        end
    end
`else
`endif

endmodule

// File: tb/tb_tid_reorder_buffer.sv
// Directed bench: in-order, out-of-order, wrap, count/backpressure and reset scenarios.
module tb_tid_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        i_v, o_r;
    logic [5:0]  i_a;
    logic [7:0]  i_d;
    logic [15:0] c64;
    logic        f64, v64;
    logic [7:0]  d64;

    logic        i_v8, o_r8;
    logic [2:0]  i_a8;
    logic [7:0]  i_d8;
    logic [15:0] c8;
    logic        f8, v8;
    logic [7:0]  d8;

    int          n_total = 0;
    int          n_pass  = 0;

    always #5 clk = ~clk;

    tid_reorder_buffer #(.W(8), .D(64), .FULL_MARGIN(16)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .i_v(i_v), .i_a(i_a), .i_d(i_d),
        .i_c(c64), .i_f(f64), .o_r(o_r), .o_v(v64), .o_d(d64)
    );

    tid_reorder_buffer #(.W(8), .D(8), .FULL_MARGIN(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .i_v(i_v8), .i_a(i_a8), .i_d(i_d8),
        .i_c(c8), .i_f(f8), .o_r(o_r8), .o_v(v8), .o_d(d8)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wr64(input logic [5:0] a, input logic [7:0] d, input logic r);
        i_v = 1'b1; i_a = a; i_d = d; o_r = r;
    endtask

    task automatic wr8(input logic [2:0] a, input logic [7:0] d, input logic r);
        i_v8 = 1'b1; i_a8 = a; i_d8 = d; o_r8 = r;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        i_v = 1'b0; o_r = 1'b0; i_v8 = 1'b0; o_r8 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_o_v", 32'(v64), 0);
        chk("rst_i_c", 32'(c64), 0);
        chk("rst_i_f", 32'(f64), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        i_v = 1'b0; i_a = '0; i_d = '0; o_r = 1'b0;
        i_v8 = 1'b0; i_a8 = '0; i_d8 = '0; o_r8 = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_o_v8", 32'(v8), 0);
        chk("init_i_c8", 32'(c8), 0);
        chk("init_i_f8", 32'(f8), 0);
        pulse_reset();

        // In-order: tags 0,1,2 with d=1,0,1, consumer always ready.
        wr64(6'd0, 8'd1, 1'b1); tick();
        chk("io_v0", 32'(v64), 1); chk("io_d0", 32'(d64), 1); chk("io_c0", 32'(c64), 1);
        wr64(6'd1, 8'd0, 1'b1); tick();
        chk("io_v1", 32'(v64), 1); chk("io_d1", 32'(d64), 0); chk("io_c1", 32'(c64), 1);
        wr64(6'd2, 8'd1, 1'b1); tick();
        chk("io_v2", 32'(v64), 1); chk("io_d2", 32'(d64), 1);
        i_v = 1'b0; tick();
        chk("io_drain_v", 32'(v64), 0); chk("io_drain_c", 32'(c64), 0);

        // Out-of-order: tags 2,1,0; nothing presented until tag 0 lands.
        pulse_reset();
        wr64(6'd2, 8'h22, 1'b1); tick();
        chk("ooo_v_t2", 32'(v64), 0); chk("ooo_c_t2", 32'(c64), 1);
        wr64(6'd1, 8'h11, 1'b1); tick();
        chk("ooo_v_t1", 32'(v64), 0); chk("ooo_c_t1", 32'(c64), 2);
        wr64(6'd0, 8'h0a, 1'b1); tick();
        chk("ooo_v_t0", 32'(v64), 1); chk("ooo_d_t0", 32'(d64), 8'h0a); chk("ooo_c_t0", 32'(c64), 3);
        i_v = 1'b0; tick();
        chk("ooo_v_p1", 32'(v64), 1); chk("ooo_d_p1", 32'(d64), 8'h11); chk("ooo_c_p1", 32'(c64), 2);
        tick();
        chk("ooo_v_p2", 32'(v64), 1); chk("ooo_d_p2", 32'(d64), 8'h22); chk("ooo_c_p2", 32'(c64), 1);
        tick();
        chk("ooo_v_p3", 32'(v64), 0); chk("ooo_c_p3", 32'(c64), 0);
        o_r = 1'b0;

        // Wrap on D=8: fill all slots, drain them, then tag 0 again, then tag 1.
        for (int i = 0; i < 8; i++) begin
            wr8(3'(i), 8'(8'h40 + i), 1'b0); tick();
        end
        i_v8 = 1'b0;
        chk("wrap_full_c", 32'(c8), 8); chk("wrap_full_f", 32'(f8), 1);
        o_r8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("wrap_pop_v", 32'(v8), 1); chk("wrap_pop_d", 32'(d8), 32'(8'h40 + k));
            tick();
        end
        chk("wrap_empty_v", 32'(v8), 0); chk("wrap_empty_c", 32'(c8), 0); chk("wrap_empty_f", 32'(f8), 0);
        wr8(3'd0, 8'h55, 1'b1); tick();
        chk("wrap_t0_v", 32'(v8), 1); chk("wrap_t0_d", 32'(d8), 8'h55);
        i_v8 = 1'b0; tick();
        chk("wrap_t0_pop_v", 32'(v8), 0); chk("wrap_t0_pop_c", 32'(c8), 0);
        wr8(3'd2, 8'h77, 1'b0); tick();
        chk("wrap_t2_v", 32'(v8), 0);
        wr8(3'd1, 8'h66, 1'b0); tick();
        chk("wrap_t1_v", 32'(v8), 1); chk("wrap_t1_d", 32'(d8), 8'h66);
        i_v8 = 1'b0;

        // Backpressure and count on D=64: 48 writes with consumer stalled.
        pulse_reset();
        for (int i = 0; i < 48; i++) begin
            wr64(6'(i), 8'(i), 1'b0); tick();
            if (i == 46) begin
                chk("bp_c47", 32'(c64), 47); chk("bp_f47", 32'(f64), 0);
            end
        end
        i_v = 1'b0;
        chk("bp_c48", 32'(c64), 48); chk("bp_f48", 32'(f64), 1);
        chk("bp_head_d", 32'(d64), 0);
        o_r = 1'b1; tick();
        o_r = 1'b0;
        chk("bp_pop_c", 32'(c64), 47); chk("bp_pop_f", 32'(f64), 0);
        chk("bp_pop_v", 32'(v64), 1); chk("bp_pop_d", 32'(d64), 1);
        wr64(6'd5, 8'haa, 1'b0); tick();
        chk("ovw_c", 32'(c64), 47); chk("ovw_d_head", 32'(d64), 1);
        wr64(6'd1, 8'hbb, 1'b1); tick();
        chk("popwr_c", 32'(c64), 47); chk("popwr_v", 32'(v64), 1); chk("popwr_d", 32'(d64), 2);
        i_v = 1'b0; o_r = 1'b0;

        // Mid-operation reset with a write held during reset; write right after release.
        @(negedge clk);
        wr64(6'd3, 8'h99, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_v", 32'(v64), 0); chk("mid_rst_c", 32'(c64), 0); chk("mid_rst_f", 32'(f64), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr64(6'd0, 8'h77, 1'b0); tick();
        chk("post_rst_v", 32'(v64), 1); chk("post_rst_d", 32'(d64), 8'h77); chk("post_rst_c", 32'(c64), 1);
        i_v = 1'b0; o_r = 1'b1; tick();
        chk("post_rst_pop_v", 32'(v64), 0); chk("post_rst_pop_c", 32'(c64), 0);
        o_r = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tid_reorder_buffer.md
TID_REORDER_BUFFER -- requirements
Module: tid_reorder_buffer

Interface
REQ-001 SHALL have parameter W, default 1: payload width in bits.
REQ-002 SHALL have parameter D, default 2048: entry count, power of two, 2..32768; AW = $clog2(D).
REQ-003 SHALL have parameter FULL_MARGIN, default 16: free-slot threshold for i_f.
REQ-004 SHALL have port clk  input  1: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_v  input  1: result write strobe.
REQ-007 SHALL have port i_a  input  AW: transaction tag (slot index) of the write.
REQ-008 SHALL have port i_d  input  W: result payload.
REQ-009 SHALL have port i_c  output  16: occupied-slot count (written, not yet popped).
REQ-010 SHALL have port i_f  output  1: almost-full flag to the tag issuer.
REQ-011 SHALL have port o_r  input  1: consumer ready.
REQ-012 SHALL have port o_v  output  1: head entry valid (show-ahead).
REQ-013 SHALL have port o_d  output  W: head entry payload.

Function
REQ-014 SHALL keep head pointer rd_ptr (AW bits, reset 0) and one valid bit plus W-bit payload per slot.
REQ-015 SHALL, on i_v, store i_d into slot i_a and set its valid bit; writes arrive in any tag order.
REQ-016 SHALL drive o_v = valid[rd_ptr] and o_d = payload[rd_ptr] with no pop required to present data.
REQ-017 SHALL pop when o_v & o_r: clear valid[rd_ptr], rd_ptr <= rd_ptr+1 modulo D (wrap D-1 -> 0).
REQ-018 SHALL ignore o_r while o_v is low; o_d is don't-care while o_v is low.
REQ-019 SHALL assert o_v exactly one cycle after a write to the slot equal to rd_ptr (write cycle N -> o_v at N+1).
REQ-020 SHALL sustain one pop per cycle when consecutive slots are valid; after a pop at cycle N, o_v/o_d reflect the new head at N+1 with no bubble.
REQ-021 SHALL, on a write to a slot already valid, overwrite the payload and keep the slot valid (count unchanged).
REQ-022 SHALL, when a write targets the slot popped in the same cycle, leave that slot valid with the new payload.
REQ-023 SHALL register i_c: +1 per write to an invalid slot, -1 per pop, both same cycle -> unchanged; saturate at D.
REQ-024 SHALL register i_f = (i_c >= D - FULL_MARGIN), updated same cycle as i_c.
REQ-025 SHALL NOT block writes when i_f is high; flow control is the issuer's duty.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all valid bits, rd_ptr, i_c, i_f and o_v; payload storage need not reset.
REQ-027 SHALL discard writes and pops while rst_n is low; mid-operation reset drops all pending entries.
REQ-028 SHALL accept writes in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with macro TID_REORDER_CHECK_EN defined, include simulation assertions flagging a write to an already-valid slot and any X on i_v/o_r out of reset; without it, no checking logic or messages exist and behaviour per REQ-021 is unchanged.

Structure
REQ-030 SHALL need no shared package content; W, D, FULL_MARGIN stay module parameters.
REQ-031 SHALL place payload storage in one sub-module sdp_ram (simple dual-port, one write, one read, same clock); valid bits, pointer and counters in flops in the top module.

Verification
REQ-032 SHALL cover in-order: tags 0,1,2 with d=1,0,1, o_r=1 -> o_d sequence 1,0,1, o_v one cycle after each write.
REQ-033 SHALL cover out-of-order: write tag 2 then 1 then 0, o_r=1 -> o_v low until tag 0 written, then three back-to-back pops in tag order.
REQ-034 SHALL cover wrap: D=8, pop 8 entries, write tag 0 again -> popped, rd_ptr returns to 1.
REQ-035 SHALL cover backpressure/count: D=64, write 48 tags with o_r=0 -> i_c=48, i_f=1; pop one -> i_c=47, i_f=0.
REQ-036 SHALL cover reset: 5 entries pending, pulse rst_n low -> o_v=0, i_c=0, i_f=0; write tag 0 -> o_v=1 next cycle.
